// File: rtl/bc_datapath.sv
// BC-I basic computer common-bus datapath: AR/PC/DR/AC/IR/TR, E flag, ALU and
// word-addressed memory, driven cycle by cycle by the controller's strobes.
module bc_datapath #(
  parameter int WIDTH      = 16,
  parameter int AW         = 12,
  parameter int MEM_DEPTH  = 4096,
  parameter int CTRL_LNGTH = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            BUS_SEL,
  input  logic [CTRL_LNGTH-1:0] CTRL_SGNLS,
  output logic [WIDTH-1:0]      IR,
  output logic [WIDTH-1:0]      AC,
  output logic                  E,
  output logic                  AC_ZERO,
  output logic                  AC_NEG,
  output logic                  DR_ZERO,
  output logic [WIDTH-1:0]      BUS
);

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_ADD = 3'b001,
    ALU_LDR = 3'b010,
    ALU_CMA = 3'b011,
    ALU_CIR = 3'b100,
    ALU_CIL = 3'b101,
    ALU_INP = 3'b110,
    ALU_CLE = 3'b111
  } alu_op_e;

  logic            ar_ld, ar_inr, ar_clr;
  logic            pc_ld, pc_inr, pc_clr;
  logic            dr_ld, dr_inr, dr_clr;
  logic            ac_ld, ac_inr, ac_clr;
  logic            ir_ld;
  logic            tr_ld, tr_inr, tr_clr;
  logic            mem_wr;
  alu_op_e         alu_op;

  logic [AW-1:0]    ar_q, ar_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0] dr_q, dr_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] tr_q, tr_d;
  logic             e_q, e_d;

  logic [WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [WIDTH-1:0] mem_rd;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] alu_ac;
  logic             alu_e;

  assign ar_ld  = CTRL_SGNLS[0];
  assign ar_inr = CTRL_SGNLS[1];
  assign ar_clr = CTRL_SGNLS[2];
  assign pc_ld  = CTRL_SGNLS[3];
  assign pc_inr = CTRL_SGNLS[4];
  assign pc_clr = CTRL_SGNLS[5];
  assign dr_ld  = CTRL_SGNLS[6];
  assign dr_inr = CTRL_SGNLS[7];
  assign dr_clr = CTRL_SGNLS[8];
  assign ac_ld  = CTRL_SGNLS[9];
  assign ac_inr = CTRL_SGNLS[10];
  assign ac_clr = CTRL_SGNLS[11];
  assign ir_ld  = CTRL_SGNLS[12];
  assign tr_ld  = CTRL_SGNLS[13];
  assign tr_inr = CTRL_SGNLS[14];
  assign tr_clr = CTRL_SGNLS[15];
  assign mem_wr = CTRL_SGNLS[16];
  assign alu_op = alu_op_e'(CTRL_SGNLS[19:17]);

  // Asynchronous read: IR_LD from memory completes within the fetch cycle.
  assign mem_rd = mem_q[ar_q];

  always_comb begin
    bus = '0;
    case (BUS_SEL)
      3'b000: bus = '0;
      3'b001: bus = {{(WIDTH-AW){1'b0}}, pc_q};
      3'b010: bus = {{(WIDTH-AW){1'b0}}, ar_q};
      3'b011: bus = dr_q;
      3'b100: bus = ir_q;
      3'b101: bus = ac_q;
      3'b110: bus = mem_rd;
      3'b111: bus = tr_q;
      default: bus = '0;
    endcase
  end

  always_comb begin
    alu_ac = ac_q;
    alu_e  = e_q;
    case (alu_op)
      ALU_AND: alu_ac = ac_q & dr_q;
      ALU_ADD: {alu_e, alu_ac} = {1'b0, ac_q} + {1'b0, dr_q};
      ALU_LDR: alu_ac = dr_q;
      ALU_CMA: alu_ac = ~ac_q;
      ALU_CIR: begin
        alu_ac = {e_q, ac_q[WIDTH-1:1]};
        alu_e  = ac_q[0];
      end
      ALU_CIL: begin
        alu_ac = {ac_q[WIDTH-2:0], e_q};
        alu_e  = ac_q[WIDTH-1];
      end
      ALU_INP: alu_ac = bus;
      ALU_CLE: alu_e = 1'b0;
      default: alu_ac = ac_q;
    endcase
  end

  // Every register: clear beats load beats increment, otherwise hold.
  always_comb begin
    ar_d = ar_q;
    if (ar_clr)      ar_d = '0;
    else if (ar_ld)  ar_d = bus[AW-1:0];
    else if (ar_inr) ar_d = ar_q + 1'b1;

    pc_d = pc_q;
    if (pc_clr)      pc_d = '0;
    else if (pc_ld)  pc_d = bus[AW-1:0];
    else if (pc_inr) pc_d = pc_q + 1'b1;

    dr_d = dr_q;
    if (dr_clr)      dr_d = '0;
    else if (dr_ld)  dr_d = bus;
    else if (dr_inr) dr_d = dr_q + 1'b1;

    ac_d = ac_q;
    e_d  = e_q;
    if (ac_clr) begin
      ac_d = '0;
    end else if (ac_ld) begin
      ac_d = alu_ac;
      e_d  = alu_e;
    end else if (ac_inr) begin
      ac_d = ac_q + 1'b1;
    end

    ir_d = ir_q;
    if (ir_ld) ir_d = bus;

    tr_d = tr_q;
    if (tr_clr)      tr_d = '0;
    else if (tr_ld)  tr_d = bus;
    else if (tr_inr) tr_d = tr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q <= '0;
      pc_q <= '0;
      dr_q <= '0;
      ac_q <= '0;
      ir_q <= '0;
      tr_q <= '0;
      e_q  <= 1'b0;
    end else begin
      ar_q <= ar_d;
      pc_q <= pc_d;
      dr_q <= dr_d;
      ac_q <= ac_d;
      ir_q <= ir_d;
      tr_q <= tr_d;
      e_q  <= e_d;
    end
  end

  // Reset sits in the sensitivity list only so a write coinciding with reset
  // is dropped; the array itself keeps its contents through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && mem_wr) mem_q[ar_q] <= bus;
  end

  assign BUS     = bus;
  assign IR      = ir_q;
  assign AC      = ac_q;
  assign E       = e_q;
  assign AC_ZERO = (ac_q == '0);
  assign AC_NEG  = ac_q[WIDTH-1];
  assign DR_ZERO = (dr_q == '0);

endmodule

// File: tb/tb_bc_datapath.sv
// Directed bench for bc_datapath: a vector table for register/ALU transfers
// plus hand sequences for wrap, memory write ordering and reset.
module tb_bc_datapath;

  localparam logic [19:0] AR_LD  = 20'd1 << 0;
  localparam logic [19:0] AR_INR = 20'd1 << 1;
  localparam logic [19:0] AR_CLR = 20'd1 << 2;
  localparam logic [19:0] PC_LD  = 20'd1 << 3;
  localparam logic [19:0] PC_INR = 20'd1 << 4;
  localparam logic [19:0] PC_CLR = 20'd1 << 5;
  localparam logic [19:0] DR_LD  = 20'd1 << 6;
  localparam logic [19:0] DR_INR = 20'd1 << 7;
  localparam logic [19:0] DR_CLR = 20'd1 << 8;
  localparam logic [19:0] AC_LD  = 20'd1 << 9;
  localparam logic [19:0] AC_INR = 20'd1 << 10;
  localparam logic [19:0] AC_CLR = 20'd1 << 11;
  localparam logic [19:0] IR_LD  = 20'd1 << 12;
  localparam logic [19:0] TR_LD  = 20'd1 << 13;
  localparam logic [19:0] TR_INR = 20'd1 << 14;
  localparam logic [19:0] TR_CLR = 20'd1 << 15;
  localparam logic [19:0] MEM_WR = 20'd1 << 16;

  logic        clk;
  logic        rst_n;
  logic [2:0]  BUS_SEL;
  logic [19:0] CTRL_SGNLS;
  logic [15:0] IR, AC, BUS;
  logic        E, AC_ZERO, AC_NEG, DR_ZERO;

  int errors = 0;
  int checks = 0;

  bc_datapath dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BUS_SEL    (BUS_SEL),
    .CTRL_SGNLS (CTRL_SGNLS),
    .IR         (IR),
    .AC         (AC),
    .E          (E),
    .AC_ZERO    (AC_ZERO),
    .AC_NEG     (AC_NEG),
    .DR_ZERO    (DR_ZERO),
    .BUS        (BUS)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       nm;
    logic [2:0]  sel;
    logic [19:0] ctrl;
    logic [2:0]  obs;
    logic [15:0] bus;
    logic [15:0] ac;
    logic        e;
    logic [15:0] ir;
    logic        drz;
  } vec_t;

  vec_t vt [31];

  function automatic logic [19:0] alu(input logic [2:0] op);
    return {op, 17'b0};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] sel, input logic [19:0] ctrl);
    @(negedge clk);
    BUS_SEL    = sel;
    CTRL_SGNLS = ctrl;
    @(posedge clk);
    #1;
    CTRL_SGNLS = '0;
  endtask

  task automatic observe(input logic [2:0] sel, input logic [15:0] exp, input string nm);
    @(negedge clk);
    CTRL_SGNLS = '0;
    BUS_SEL    = sel;
    #1;
    chk(nm, BUS, exp);
  endtask

  // Builds a constant in AC by shifting bits in from the LSB (E kept at 0).
  task automatic load_ac(input logic [15:0] val);
    step(3'd0, AC_CLR);
    step(3'd0, AC_LD | alu(3'd7));
    for (int b = 15; b >= 0; b--) begin
      step(3'd0, AC_LD | alu(3'd5));
      if (val[b]) step(3'd0, AC_INR);
    end
    chk("load_ac", AC, val);
  endtask

  initial begin
    vt[0]  = '{"fetch_t0",     3'd1, AR_LD,                      3'd2, 16'h0000, 16'h7123, 1'b0, 16'h0000, 1'b1};
    vt[1]  = '{"fetch_t1",     3'd6, IR_LD | PC_INR,             3'd1, 16'h0001, 16'h7123, 1'b0, 16'h7123, 1'b1};
    vt[2]  = '{"fetch_t2",     3'd4, AR_LD,                      3'd2, 16'h0123, 16'h7123, 1'b0, 16'h7123, 1'b1};
    vt[3]  = '{"dr_from_ac",   3'd5, DR_LD,                      3'd3, 16'h7123, 16'h7123, 1'b0, 16'h7123, 1'b0};
    vt[4]  = '{"cma",          3'd0, AC_LD | alu(3'd3),          3'd5, 16'h8EDC, 16'h8EDC, 1'b0, 16'h7123, 1'b0};
    vt[5]  = '{"and",          3'd0, AC_LD | alu(3'd0),          3'd5, 16'h0000, 16'h0000, 1'b0, 16'h7123, 1'b0};
    vt[6]  = '{"ldr",          3'd0, AC_LD | alu(3'd2),          3'd5, 16'h7123, 16'h7123, 1'b0, 16'h7123, 1'b0};
    vt[7]  = '{"add",          3'd0, AC_LD | alu(3'd1),          3'd5, 16'hE246, 16'hE246, 1'b0, 16'h7123, 1'b0};
    vt[8]  = '{"add_carry",    3'd0, AC_LD | alu(3'd1),          3'd3, 16'h7123, 16'h5369, 1'b1, 16'h7123, 1'b0};
    vt[9]  = '{"cil",          3'd0, AC_LD | alu(3'd5),          3'd5, 16'hA6D3, 16'hA6D3, 1'b0, 16'h7123, 1'b0};
    vt[10] = '{"cir",          3'd0, AC_LD | alu(3'd4),          3'd5, 16'h5369, 16'h5369, 1'b1, 16'h7123, 1'b0};
    vt[11] = '{"clr_beats_ld", 3'd0, AC_CLR | AC_LD | alu(3'd7), 3'd5, 16'h0000, 16'h0000, 1'b1, 16'h7123, 1'b0};
    vt[12] = '{"cma_zero",     3'd0, AC_LD | alu(3'd3),          3'd5, 16'hFFFF, 16'hFFFF, 1'b1, 16'h7123, 1'b0};
    vt[13] = '{"dr_clr_pri",   3'd5, DR_CLR | DR_LD | DR_INR,    3'd3, 16'h0000, 16'hFFFF, 1'b1, 16'h7123, 1'b1};
    vt[14] = '{"dr_inr",       3'd0, DR_INR,                     3'd3, 16'h0001, 16'hFFFF, 1'b1, 16'h7123, 1'b0};
    vt[15] = '{"cle",          3'd0, AC_LD | alu(3'd7),          3'd5, 16'hFFFF, 16'hFFFF, 1'b0, 16'h7123, 1'b0};
    vt[16] = '{"add_wrap",     3'd0, AC_LD | alu(3'd1),          3'd5, 16'h0000, 16'h0000, 1'b1, 16'h7123, 1'b0};
    vt[17] = '{"cir_neg",      3'd0, AC_LD | alu(3'd4),          3'd5, 16'h8000, 16'h8000, 1'b0, 16'h7123, 1'b0};
    vt[18] = '{"ac_inr",       3'd0, AC_INR,                     3'd5, 16'h8001, 16'h8001, 1'b0, 16'h7123, 1'b0};
    vt[19] = '{"tr_ld",        3'd5, TR_LD,                      3'd7, 16'h8001, 16'h8001, 1'b0, 16'h7123, 1'b0};
    vt[20] = '{"tr_ld_self",   3'd7, TR_LD | TR_INR,             3'd7, 16'h8001, 16'h8001, 1'b0, 16'h7123, 1'b0};
    vt[21] = '{"tr_inr",       3'd0, TR_INR,                     3'd7, 16'h8002, 16'h8001, 1'b0, 16'h7123, 1'b0};
    vt[22] = '{"ar_self_dr",   3'd2, AR_LD | DR_LD,              3'd3, 16'h0123, 16'h8001, 1'b0, 16'h7123, 1'b0};
    vt[23] = '{"ar_hold",      3'd0, 20'd0,                      3'd2, 16'h0123, 16'h8001, 1'b0, 16'h7123, 1'b0};
    vt[24] = '{"ar_tr_multi",  3'd5, AR_LD | TR_LD,              3'd2, 16'h0001, 16'h8001, 1'b0, 16'h7123, 1'b0};
    vt[25] = '{"tr_multi",     3'd0, 20'd0,                      3'd7, 16'h8001, 16'h8001, 1'b0, 16'h7123, 1'b0};
    vt[26] = '{"tr_clr_pri",   3'd5, TR_CLR | TR_LD,             3'd7, 16'h0000, 16'h8001, 1'b0, 16'h7123, 1'b0};
    vt[27] = '{"ac_clr_inr",   3'd0, AC_CLR | AC_INR,            3'd5, 16'h0000, 16'h0000, 1'b0, 16'h7123, 1'b0};
    vt[28] = '{"cma_ones",     3'd0, AC_LD | alu(3'd3),          3'd5, 16'hFFFF, 16'hFFFF, 1'b0, 16'h7123, 1'b0};
    vt[29] = '{"ac_inr_wrap",  3'd0, AC_INR,                     3'd5, 16'h0000, 16'h0000, 1'b0, 16'h7123, 1'b0};
    vt[30] = '{"ar_inr",       3'd0, AR_INR,                     3'd2, 16'h0002, 16'h0000, 1'b0, 16'h7123, 1'b0};

    rst_n      = 1'b0;
    BUS_SEL    = 3'd0;
    CTRL_SGNLS = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ac", AC, 16'h0000);
    chk("rst_e", {15'b0, E}, 16'h0000);
    chk("rst_ir", IR, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Program M[0] = 0x7123 with AR = 0, then run the table from PC = 0.
    load_ac(16'h7123);
    step(3'd0, AR_CLR);
    step(3'd5, MEM_WR);
    observe(3'd6, 16'h7123, "mem0_wr");

    for (int i = 0; i < 31; i++) begin
      step(vt[i].sel, vt[i].ctrl);
      chk({vt[i].nm, "_ac"}, AC, vt[i].ac);
      chk({vt[i].nm, "_e"}, {15'b0, E}, {15'b0, vt[i].e});
      chk({vt[i].nm, "_ir"}, IR, vt[i].ir);
      chk({vt[i].nm, "_aczero"}, {15'b0, AC_ZERO}, {15'b0, vt[i].ac == 16'h0000});
      chk({vt[i].nm, "_acneg"}, {15'b0, AC_NEG}, {15'b0, vt[i].ac[15]});
      chk({vt[i].nm, "_drzero"}, {15'b0, DR_ZERO}, {15'b0, vt[i].drz});
      observe(vt[i].obs, vt[i].bus, {vt[i].nm, "_bus"});
    end

    // PC / AR wrap and priority with truncated loads from a 16-bit bus.
    step(3'd0, AC_CLR);
    step(3'd0, AC_LD | alu(3'd3));
    step(3'd5, PC_LD);
    observe(3'd1, 16'h0FFF, "pc_ld_trunc");
    step(3'd0, PC_INR);
    observe(3'd1, 16'h0000, "pc_wrap");
    step(3'd0, PC_INR);
    observe(3'd1, 16'h0001, "pc_inr");
    step(3'd5, PC_CLR | PC_LD | PC_INR);
    observe(3'd1, 16'h0000, "pc_clr_pri");
    step(3'd5, AR_LD);
    step(3'd0, AR_INR);
    observe(3'd2, 16'h0000, "ar_wrap");

    // Memory write, then read-during-write returns the old word.
    load_ac(16'h0010);
    step(3'd5, AR_LD);
    load_ac(16'hBEEF);
    step(3'd5, MEM_WR);
    observe(3'd6, 16'hBEEF, "mem10_wr");
    load_ac(16'h1234);
    @(negedge clk);
    BUS_SEL    = 3'd6;
    CTRL_SGNLS = MEM_WR | DR_LD;
    #1;
    chk("rdw_bus", BUS, 16'hBEEF);
    @(posedge clk);
    #1;
    CTRL_SGNLS = '0;
    observe(3'd3, 16'hBEEF, "rdw_dr_old");
    observe(3'd6, 16'hBEEF, "rdw_mem");
    step(3'd5, MEM_WR);
    observe(3'd6, 16'h1234, "mem10_wr2");

    // All registers nonzero, then reset mid-cycle with a write pending.
    load_ac(16'h5A5B);
    step(3'd5, PC_LD | TR_LD);
    step(3'd0, AC_LD | alu(3'd4));
    chk("pre_rst_ac", AC, 16'h2D2D);
    chk("pre_rst_e", {15'b0, E}, 16'h0001);
    @(negedge clk);
    BUS_SEL    = 3'd5;
    CTRL_SGNLS = MEM_WR;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ac", AC, 16'h0000);
    chk("arst_e", {15'b0, E}, 16'h0000);
    chk("arst_ir", IR, 16'h0000);
    chk("arst_bus", BUS, 16'h0000);
    @(posedge clk);
    #1;
    CTRL_SGNLS = '0;
    observe(3'd1, 16'h0000, "arst_pc");
    observe(3'd2, 16'h0000, "arst_ar");
    observe(3'd3, 16'h0000, "arst_dr");
    observe(3'd7, 16'h0000, "arst_tr");
    @(negedge clk);
    BUS_SEL    = 3'd0;
    CTRL_SGNLS = AC_INR;
    rst_n      = 1'b1;
    @(posedge clk);
    #1;
    CTRL_SGNLS = '0;
    chk("rel_first_edge", AC, 16'h0001);
    load_ac(16'h0010);
    step(3'd5, AR_LD);
    observe(3'd6, 16'h1234, "rst_no_write");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bc_datapath.md
Name: bc_datapath

Overview:
- Common-bus datapath of the BC-I basic computer. It is the responder to the controller: it consumes BUS_SEL and CTRL_SGNLS every cycle and executes register transfers, memory accesses and ALU operations.
- Holds AR, PC, DR, AC, IR, TR, the E flip-flop and word-addressed memory.
- Returns IR and status flags to the controller.

Parameters:
- WIDTH, 16, data/bus width; DR, AC, IR, TR and memory words are this wide.
- AW, 12, address width of AR and PC.
- MEM_DEPTH, 4096, number of memory words; must be 2**AW.
- CTRL_LNGTH, 20, width of CTRL_SGNLS.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- BUS_SEL  in  3  bus source select
- CTRL_SGNLS  in  CTRL_LNGTH  micro-operation strobes
- IR  out  WIDTH  instruction register, to controller
- AC  out  WIDTH  accumulator
- E  out  1  carry/extend flip-flop
- AC_ZERO  out  1  AC == 0 (combinational)
- AC_NEG  out  1  AC[WIDTH-1]
- DR_ZERO  out  1  DR == 0 (combinational)
- BUS  out  WIDTH  current bus value, for observation

Behaviour:
- Bus (combinational) by BUS_SEL:
  - 000 = 0
  - 001 = PC, zero-extended
  - 010 = AR, zero-extended
  - 011 = DR
  - 100 = IR
  - 101 = AC
  - 110 = M[AR]
  - 111 = TR
  - All 8 codes are legal.
- CTRL_SGNLS bits:
  - AR: 0 AR_LD, 1 AR_INR, 2 AR_CLR
  - PC: 3 PC_LD, 4 PC_INR, 5 PC_CLR
  - DR: 6 DR_LD, 7 DR_INR, 8 DR_CLR
  - AC: 9 AC_LD, 10 AC_INR, 11 AC_CLR
  - 12 IR_LD
  - TR: 13 TR_LD, 14 TR_INR, 15 TR_CLR
  - 16 MEM_WR
  - 19:17 ALU_OP
- Per register, priority at the rising edge is CLR > LD > INR; with none asserted the register holds.
- AR/PC load BUS[AW-1:0]. DR/IR/TR load BUS. AC_LD loads the ALU result, not BUS.
- INR wraps modulo 2**width (AR/PC 0xFFF->0x000; DR/AC/TR 0xFFFF->0x0000); E unaffected.
- Memory:
  - Read is combinational from AR. IR_LD with BUS_SEL=110 therefore completes in the same cycle as in fetch T1.
  - MEM_WR writes BUS into M[AR] at the edge.
  - Same-cycle read of M[AR] while MEM_WR sees the old contents.
  - Memory is not cleared by reset.
- ALU_OP, applied when AC_LD=1:
  - 000 AND: AC&DR
  - 001 ADD: {E,AC} <= AC+DR, E = carry out
  - 010 LDR: DR
  - 011 CMA: ~AC
  - 100 CIR: {AC,E} <= {E,AC[W-1:1]}, AC[0]
  - 101 CIL: {E,AC} <= {AC,E}
  - 110 INP: BUS
  - 111 CLE: AC holds, E <= 0
- E changes only under AC_LD with ADD/CIR/CIL/CLE, and also on AC_CLR+AC_LD? No: AC_CLR wins and E holds.
- Any register may be bus source and destination in one cycle: the destination gets the pre-edge value. Example: AR_LD with BUS_SEL=010 holds AR.
- Multiple simultaneous loads from one bus value are legal (e.g. AR_LD+TR_LD).
- Reset (rst_n=0, async): AR, PC, DR, AC, IR, TR, E = 0 immediately, therefore BUS=0 for BUS_SEL≠110. Reset mid-operation drops any pending write; on release, the first edge executes the current strobes.
- Latency: all register/memory updates take effect at the next rising edge; flags and BUS are combinational.

Test Plan:
- Reset with all registers nonzero -> AR=PC=DR=AC=IR=TR=0, E=0 without a clock edge. Release, then run fetch: T0 BUS_SEL=001 + AR_LD; T1 BUS_SEL=110 + IR_LD + PC_INR; T2 BUS_SEL=100 + AR_LD. With M[0]=0x7123, expect after T2 IR=0x7123, PC=1, AR=0x123.
- AC=0xFFFF, DR=0x0001, AC_LD with ALU_OP=ADD -> AC=0x0000, E=1, AC_ZERO=1; then CIR -> AC=0x8000, E=0, AC_NEG=1.
- PC=0xFFF with PC_INR -> PC=0x000. PC_CLR+PC_LD+PC_INR together -> PC=0.
- AR=0x010, AC=0xBEEF, BUS_SEL=101 + MEM_WR -> M[0x010]=0xBEEF next cycle. Same-cycle DR_LD from BUS_SEL=110 during a write gets the old word.
- BUS_SEL=111 with TR_LD+TR_INR asserted -> TR unchanged (LD of own value beats INR). BUS_SEL=010 + AR_LD + DR_LD -> DR = old AR, AR unchanged.
- Assert rst_n=0 mid-cycle while MEM_WR is high -> no write occurs; all registers 0 immediately.
